// File: rtl/esp32_boot_sequencer.sv
// ---------------------------------------------------------------------------
// esp32_boot_sequencer
//
// Restarts an ESP32 into normal run or into the serial bootloader by driving
// its EN and strap pins open-drain with timed phases. This replaces the host
// DTR/RTS auto-reset dance: the FPGA pulls EN low, presents the straps,
// releases EN while the straps are still held, and then releases the straps.
//
// Phases: IDLE -> ASSERT (EN low, straps driven)
//              -> STRAP  (EN released, straps still driven)
//              -> DONE   (everything released, one-cycle done pulse) -> IDLE
//
// Parameters:
//   C_en_low_cycles     cycles EN is held low (>= 1)
//   C_strap_hold_cycles cycles straps stay driven after EN release (>= 1)
//
// Ports:
//   clk_25mhz  in   system clock
//   rstn       in   asynchronous active-low reset
//   req        in   start request, honoured only in IDLE
//   boot       in   mode, sampled with req: 1 = bootloader, 0 = normal run
//   abort      in   release all pins and return to IDLE on the next edge
//   busy       out  high in ASSERT and STRAP
//   done       out  one-cycle pulse on normal completion
//   phase      out  0 IDLE, 1 ASSERT, 2 STRAP, 3 DONE
//   en_oe      out  1 = drive wifi_en low
//   gpio0_oe   out  1 = drive wifi_gpio0 low
//   gpio2_oe   out  1 = drive wifi_gpio2 low (mirrors gpio0_oe)
//   gpio12_oe  out  1 = drive wifi_gpio12 low
//
// Build option:
//   ESP32_SEQ_GPIO12_EN  when defined, gpio12_oe is driven in ASSERT and STRAP
//                        regardless of mode (3.3 V flash strap on modules with
//                        an unprogrammed VDD_SDIO fuse). Otherwise it is tied 0.
// ---------------------------------------------------------------------------
module esp32_boot_sequencer #(
    parameter int C_en_low_cycles     = 2500000,
    parameter int C_strap_hold_cycles = 1250000
) (
    input  logic       clk_25mhz,
    input  logic       rstn,
    input  logic       req,
    input  logic       boot,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [1:0] phase,
    output logic       en_oe,
    output logic       gpio0_oe,
    output logic       gpio2_oe,
    output logic       gpio12_oe
);

    localparam int C_MAX = (C_en_low_cycles > C_strap_hold_cycles) ?
                           C_en_low_cycles : C_strap_hold_cycles;
    localparam int CW    = $clog2(C_MAX + 1);

    localparam logic [CW-1:0] C_EN_LOAD    = CW'(C_en_low_cycles);
    localparam logic [CW-1:0] C_STRAP_LOAD = CW'(C_strap_hold_cycles);
    localparam logic [CW-1:0] C_ONE        = CW'(1);

    // Zero-length phases would make the down-counter meaningless.
    if (C_en_low_cycles < 1) begin : g_bad_en_low
        $error("esp32_boot_sequencer: C_en_low_cycles must be >= 1");
    end
    if (C_strap_hold_cycles < 1) begin : g_bad_strap_hold
        $error("esp32_boot_sequencer: C_strap_hold_cycles must be >= 1");
    end

    // Encoding doubles as the phase output.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_STRAP  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_mode;
    logic          w_mode_nxt;

    logic          r_busy;
    logic          r_done;
    logic [1:0]    r_phase;
    logic          r_en_oe;
    logic          r_gpio0_oe;

    logic          w_drive_nxt;
    logic          w_busy_nxt;
    logic          w_done_nxt;
    logic [1:0]    w_phase_nxt;
    logic          w_en_oe_nxt;
    logic          w_gpio0_oe_nxt;

    // -----------------------------------------------------------------------
    // State, counter, mode and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_25mhz or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_mode     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_phase    <= 2'd0;
            r_en_oe    <= 1'b0;
            r_gpio0_oe <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mode     <= w_mode_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_phase    <= w_phase_nxt;
            r_en_oe    <= w_en_oe_nxt;
            r_gpio0_oe <= w_gpio0_oe_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next state / next outputs
    // Outputs are computed from the next state so that the registered pins
    // change on the same edge as the state register.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;

        if (abort) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        w_state_nxt = S_ASSERT;
                        w_cnt_nxt   = C_EN_LOAD;
                        w_mode_nxt  = boot;
                    end
                end
                S_ASSERT: begin
                    if (r_cnt == C_ONE) begin
                        w_state_nxt = S_STRAP;
                        w_cnt_nxt   = C_STRAP_LOAD;
                    end else begin
                        w_cnt_nxt = r_cnt - C_ONE;
                    end
                end
                S_STRAP: begin
                    if (r_cnt == C_ONE) begin
                        w_state_nxt = S_DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - C_ONE;
                    end
                end
                S_DONE: begin
                    // req is deliberately not looked at here: one dead cycle.
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        w_drive_nxt    = (w_state_nxt == S_ASSERT) || (w_state_nxt == S_STRAP);
        w_busy_nxt     = w_drive_nxt;
        w_done_nxt     = (w_state_nxt == S_DONE);
        w_phase_nxt    = w_state_nxt;
        w_en_oe_nxt    = (w_state_nxt == S_ASSERT);
        // gpio0 only moves on IDLE->ASSERT and STRAP->DONE, never with EN.
        w_gpio0_oe_nxt = w_drive_nxt && w_mode_nxt;
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign phase    = r_phase;
    assign en_oe    = r_en_oe;
    assign gpio0_oe = r_gpio0_oe;
    assign gpio2_oe = r_gpio0_oe;

`ifdef ESP32_SEQ_GPIO12_EN
    logic r_gpio12_oe;

    always_ff @(posedge clk_25mhz or negedge rstn) begin
        if (!rstn) begin
            r_gpio12_oe <= 1'b0;
        end else begin
            r_gpio12_oe <= w_drive_nxt;
        end
    end

    assign gpio12_oe = r_gpio12_oe;
`else
    assign gpio12_oe = 1'b0;
`endif

endmodule

// File: tb/tb_esp32_boot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_esp32_boot_sequencer
//
// Directed bench for esp32_boot_sequencer with C_en_low_cycles=10 and
// C_strap_hold_cycles=5. Cycle k is the interval after clock edge k; inputs
// are changed and outputs sampled 1 ns after the edge. A request presented in
// cycle 0 gives EN low in cycles 1-10, straps in 1-15 and done in cycle 16.
// Honours ESP32_SEQ_GPIO12_EN for the gpio12_oe expectation.
// ---------------------------------------------------------------------------
module tb_esp32_boot_sequencer;

    localparam int C_EN = 10;
    localparam int C_ST = 5;

    logic       clk_25mhz;
    logic       rstn;
    logic       req;
    logic       boot;
    logic       abort;
    logic       busy;
    logic       done;
    logic [1:0] phase;
    logic       en_oe;
    logic       gpio0_oe;
    logic       gpio2_oe;
    logic       gpio12_oe;

    int n_chk;
    int n_err;

    esp32_boot_sequencer #(
        .C_en_low_cycles    (C_EN),
        .C_strap_hold_cycles(C_ST)
    ) dut (
        .clk_25mhz(clk_25mhz),
        .rstn     (rstn),
        .req      (req),
        .boot     (boot),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .phase    (phase),
        .en_oe    (en_oe),
        .gpio0_oe (gpio0_oe),
        .gpio2_oe (gpio2_oe),
        .gpio12_oe(gpio12_oe)
    );

    initial clk_25mhz = 1'b0;
    always #20 clk_25mhz = ~clk_25mhz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25mhz);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " en_oe"},     en_oe,     1'b0);
        chk({tag, " gpio0_oe"},  gpio0_oe,  1'b0);
        chk({tag, " gpio2_oe"},  gpio2_oe,  1'b0);
        chk({tag, " gpio12_oe"}, gpio12_oe, 1'b0);
        chk({tag, " busy"},      busy,      1'b0);
        chk({tag, " done"},      done,      1'b0);
        chk({tag, " phase"},     phase,     2'd0);
    endtask

    // One sequence of 21 cycles with req presented in cycle 0.
    // abort_at < 0 means no abort; toggle_boot flips boot every later cycle.
    task automatic run_seq(input string tag, input bit b, input int abort_at,
                           input bit toggle_boot);
        bit          act;
        bit          exp_en;
        bit          exp_g0;
        bit          exp_g12;
        bit          exp_busy;
        bit          exp_done;
        logic [1:0]  exp_ph;
        string       t;
        for (int k = 0; k <= 20; k++) begin
            req   = (k == 0);
            boot  = (k == 0) ? b : (toggle_boot ? ~boot : boot);
            abort = (k == abort_at);
            act      = (k >= 1) && (k <= C_EN + C_ST);
            exp_en   = (k >= 1) && (k <= C_EN);
            exp_done = (k == C_EN + C_ST + 1);
            exp_ph   = (k == 0) ? 2'd0 :
                       (k <= C_EN) ? 2'd1 :
                       (k <= C_EN + C_ST) ? 2'd2 :
                       (k == C_EN + C_ST + 1) ? 2'd3 : 2'd0;
            if (abort_at >= 0 && k > abort_at) begin
                act      = 1'b0;
                exp_en   = 1'b0;
                exp_done = 1'b0;
                exp_ph   = 2'd0;
            end
            exp_busy = act;
            exp_g0   = act && b;
`ifdef ESP32_SEQ_GPIO12_EN
            exp_g12  = act;
`else
            exp_g12  = 1'b0;
`endif
            t = $sformatf("%s c%0d", tag, k);
            chk({t, " en_oe"},     en_oe,     exp_en);
            chk({t, " gpio0_oe"},  gpio0_oe,  exp_g0);
            chk({t, " gpio2_oe"},  gpio2_oe,  exp_g0);
            chk({t, " gpio12_oe"}, gpio12_oe, exp_g12);
            chk({t, " busy"},      busy,      exp_busy);
            chk({t, " done"},      done,      exp_done);
            chk({t, " phase"},     phase,     exp_ph);
            tick();
        end
        req   = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        int n_done;
        int n_rise;
        logic prev_en;

        n_chk = 0;
        n_err = 0;
        rstn  = 1'b0;
        req   = 1'b0;
        boot  = 1'b0;
        abort = 1'b0;

        // Reset
        tick();
        tick();
        chk_idle("reset");
        rstn = 1'b1;
        tick();
        chk_idle("post-reset");

        // Boot and run sequences, boot with toggling boot input
        run_seq("boot", 1'b1, -1, 1'b0);
        run_seq("run",  1'b0, -1, 1'b0);
        run_seq("boot-toggle", 1'b1, -1, 1'b1);
        run_seq("run-toggle",  1'b0, -1, 1'b1);

        // Abort during STRAP, and during ASSERT
        run_seq("abort12", 1'b1, 12, 1'b0);
        run_seq("abort4",  1'b0, 4,  1'b0);

        // req and abort together in IDLE: stays IDLE
        req   = 1'b1;
        boot  = 1'b1;
        abort = 1'b1;
        tick();
        req   = 1'b0;
        abort = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            chk_idle($sformatf("req+abort c%0d", k));
            tick();
        end

        // req held high: second sequence starts in cycle 17 (EN low from 18)
        n_done  = 0;
        n_rise  = 0;
        prev_en = 1'b0;
        req     = 1'b1;
        boot    = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            if (done) n_done++;
            if (en_oe && !prev_en) n_rise++;
            prev_en = en_oe;
            if (k == 11) chk("hold c11 phase", phase, 2'd2);
            if (k == 17) chk("hold c17 en_oe", en_oe, 1'b0);
            if (k == 17) chk("hold c17 phase", phase, 2'd0);
            if (k == 18) chk("hold c18 en_oe", en_oe, 1'b1);
            if (k == 18) chk("hold c18 gpio0_oe", gpio0_oe, 1'b1);
            if (k == 33) chk("hold c33 done", done, 1'b1);
            tick();
        end
        req = 1'b0;
        chk("hold done pulses", n_done, 2);
        chk("hold en rises", n_rise, 3);
        // Let the third sequence finish.
        for (int k = 0; k < 20; k++) tick();
        chk_idle("hold drained");

        // Asynchronous reset mid-sequence releases everything at once
        req  = 1'b1;
        boot = 1'b1;
        tick();
        req = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        chk("rst c5 en_oe before", en_oe, 1'b1);
        chk("rst c5 gpio0_oe before", gpio0_oe, 1'b1);
        #5;
        rstn = 1'b0;
        #1;
        chk_idle("async rst");
        tick();
        rstn = 1'b1;
        tick();
        chk_idle("after rst");
        run_seq("boot-after-rst", 1'b1, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
